// File: rtl/cv32e40s_data_obi_bounded_interface.sv
// ----------------------------------------------------------------------------
// cv32e40s_data_obi_bounded_interface
//
// Data-side OBI master adapter sitting between the load/store unit and the
// data OBI bus. Requests on trans_* become OBI A-channel transfers. R-channel
// responses pass straight through to resp_* with zero latency. Each response
// is tagged with the write flag of the transaction it answers.
//
// The A-channel payload is held stable in a hold register while the bus
// withholds grant. The number of accepted-but-unanswered transactions is
// bounded by MAX_OUTSTANDING.
//
// Handshakes:
//   trans_*  : a request is taken when trans_valid_i && trans_ready_o. The
//              requester may change trans_* on the following cycle.
//   data A   : a transfer is accepted when data_req_o && data_gnt_i. While
//              req is high and gnt is low, the payload does not change.
//   data R   : data_rvalid_i is always accepted; resp_* has no backpressure.
//
// Optional feature (macro CV32E40S_DATA_OBI_ACHK_EN):
//   When the macro is defined, data_achk_o carries per-byte parity of the
//   A-channel. From the MSB down it holds:
//     - the wdata bytes, high to low, each as an even-parity bit;
//     - {be,we} as an odd-parity bit;
//     - the addr bytes, high to low, each as an even-parity bit.
//   When the macro is undefined, data_achk_o is tied to 0.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   trans_*           load/store unit request side
//   resp_*            response side (valid, rdata, err, write flag)
//   data_*            OBI A/R channel, including the inverted-parity companions
//                     of req, gnt and rvalid
//   outstanding_o     current outstanding transaction count
//   integrity_err_o   parity mismatch on gnt or rvalid this cycle
//   protocol_err_o    rvalid seen with nothing outstanding this cycle
// ----------------------------------------------------------------------------
module cv32e40s_data_obi_bounded_interface #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      trans_valid_i,
    output logic                                      trans_ready_o,
    input  logic [ADDR_WIDTH-1:0]                     trans_addr_i,
    input  logic                                      trans_we_i,
    input  logic [DATA_WIDTH/8-1:0]                   trans_be_i,
    input  logic [DATA_WIDTH-1:0]                     trans_wdata_i,
    output logic                                      resp_valid_o,
    output logic [DATA_WIDTH-1:0]                     resp_rdata_o,
    output logic                                      resp_err_o,
    output logic                                      resp_we_o,
    output logic                                      data_req_o,
    output logic                                      data_reqpar_o,
    input  logic                                      data_gnt_i,
    input  logic                                      data_gntpar_i,
    output logic [ADDR_WIDTH-1:0]                     data_addr_o,
    output logic                                      data_we_o,
    output logic [DATA_WIDTH/8-1:0]                   data_be_o,
    output logic [DATA_WIDTH-1:0]                     data_wdata_o,
    output logic [DATA_WIDTH/8+ADDR_WIDTH/8:0]        data_achk_o,
    input  logic                                      data_rvalid_i,
    input  logic                                      data_rvalidpar_i,
    input  logic [DATA_WIDTH-1:0]                     data_rdata_i,
    input  logic                                      data_err_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]      outstanding_o,
    output logic                                      integrity_err_o,
    output logic                                      protocol_err_o
);

    localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   hold_addr_q, hold_addr_d;
    logic                    hold_we_q, hold_we_d;
    logic [BE_WIDTH-1:0]     hold_be_q, hold_be_d;
    logic [DATA_WIDTH-1:0]   hold_wdata_q, hold_wdata_d;
    logic [CNT_WIDTH-1:0]    count_q, count_d;
    // In-order write flags of outstanding transactions; entry 0 is the oldest.
    logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;

    logic                    full;
    logic                    req_raw;
    logic                    accept;
    logic                    resp_pop;
    logic [CNT_WIDTH-1:0]    wr_idx;

    assign full = (count_q == CNT_MAX);

    // ------------------------------------------------------------------
    // A-channel FSM: next state, hold register and A-channel outputs.
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        hold_addr_d   = hold_addr_q;
        hold_we_d     = hold_we_q;
        hold_be_d     = hold_be_q;
        hold_wdata_d  = hold_wdata_q;
        trans_ready_o = 1'b0;
        req_raw       = 1'b0;
        data_addr_o   = trans_addr_i;
        data_we_o     = trans_we_i;
        data_be_o     = trans_be_i;
        data_wdata_o  = trans_wdata_i;

        unique case (state_q)
            IDLE: begin
                trans_ready_o = !full;
                req_raw       = trans_valid_i && !full;
                // Without a grant the request is parked in the hold register.
                // The requester is released now and may move on.
                if (req_raw && !data_gnt_i) begin
                    hold_addr_d  = trans_addr_i;
                    hold_we_d    = trans_we_i;
                    hold_be_d    = trans_be_i;
                    hold_wdata_d = trans_wdata_i;
                    state_d      = PENDING;
                end
            end
            PENDING: begin
                req_raw      = 1'b1;
                data_addr_o  = hold_addr_q;
                data_we_o    = hold_we_q;
                data_be_o    = hold_be_q;
                data_wdata_o = hold_wdata_q;
                if (data_gnt_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // req drops the moment reset asserts, without waiting for a clock edge.
    assign data_req_o    = req_raw && rst_n;
    assign data_reqpar_o = !data_req_o;

    // ------------------------------------------------------------------
    // Outstanding counter and write-flag FIFO.
    // ------------------------------------------------------------------
    always_comb begin
        accept   = data_req_o && data_gnt_i;
        resp_pop = data_rvalid_i && (count_q != '0);
        count_d  = count_q;
        fifo_d   = fifo_q;
        wr_idx   = count_q;

        if (resp_pop) begin
            fifo_d = fifo_q >> 1;
            // After the shift, the first free slot moves down by one.
            wr_idx = count_q - CNT_ONE;
        end

        if (accept) begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                if (i == int'(wr_idx)) begin
                    fifo_d[i] = data_we_o;
                end
            end
        end

        unique case ({accept, resp_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hold_addr_q  <= '0;
            hold_we_q    <= 1'b0;
            hold_be_q    <= '0;
            hold_wdata_q <= '0;
            count_q      <= '0;
            fifo_q       <= '0;
        end else begin
            state_q      <= state_d;
            hold_addr_q  <= hold_addr_d;
            hold_we_q    <= hold_we_d;
            hold_be_q    <= hold_be_d;
            hold_wdata_q <= hold_wdata_d;
            count_q      <= count_d;
            fifo_q       <= fifo_d;
        end
    end

    // ------------------------------------------------------------------
    // R channel: pure pass-through.
    // An unexpected rvalid is still forwarded, but it carries we=0.
    // ------------------------------------------------------------------
    assign resp_valid_o   = data_rvalid_i;
    assign resp_rdata_o   = data_rdata_i;
    assign resp_err_o     = data_err_i;
    assign resp_we_o      = (count_q != '0) ? fifo_q[0] : 1'b0;
    assign protocol_err_o = data_rvalid_i && (count_q == '0);
    assign outstanding_o  = count_q;

    // A companion equal to its signal means the inverted-parity pair is broken.
    assign integrity_err_o = (data_gnt_i == data_gntpar_i) ||
                             (data_rvalid_i == data_rvalidpar_i);

    // ------------------------------------------------------------------
    // A-channel checksum.
    // ------------------------------------------------------------------
`ifdef CV32E40S_DATA_OBI_ACHK_EN
    always_comb begin
        data_achk_o = '0;
        for (int i = 0; i < int'(ADDR_WIDTH / 8); i++) begin
            data_achk_o[i] = ^data_addr_o[i*8 +: 8];
        end
        data_achk_o[ADDR_WIDTH/8] = ~^{data_be_o, data_we_o};
        for (int i = 0; i < int'(BE_WIDTH); i++) begin
            data_achk_o[ADDR_WIDTH/8 + 1 + i] = ^data_wdata_o[i*8 +: 8];
        end
    end
`else
    assign data_achk_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40s_data_obi_bounded_interface.sv
// ----------------------------------------------------------------------------
// Testbench for cv32e40s_data_obi_bounded_interface.
//
// The reference model works at transaction level. It keeps two queues:
//   pend_q : requests taken from the requester but not yet granted
//   os_q   : write flags of granted-but-unanswered transactions
//
// Response data driven on the R channel is pushed into exp_q. A negedge
// monitor pops exp_q and compares every resp_valid_o against it.
// ----------------------------------------------------------------------------
module tb_cv32e40s_data_obi_bounded_interface;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int BW     = DW / 8;
    localparam int MAXO   = 2;
    localparam int CW     = $clog2(MAXO + 1);
    localparam int ACHK_W = DW / 8 + AW / 8 + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata;
    } txn_t;

    logic              clk;
    logic              rst_n;
    logic              trans_valid_i;
    logic              trans_ready_o;
    logic [AW-1:0]     trans_addr_i;
    logic              trans_we_i;
    logic [BW-1:0]     trans_be_i;
    logic [DW-1:0]     trans_wdata_i;
    logic              resp_valid_o;
    logic [DW-1:0]     resp_rdata_o;
    logic              resp_err_o;
    logic              resp_we_o;
    logic              data_req_o;
    logic              data_reqpar_o;
    logic              data_gnt_i;
    logic              data_gntpar_i;
    logic [AW-1:0]     data_addr_o;
    logic              data_we_o;
    logic [BW-1:0]     data_be_o;
    logic [DW-1:0]     data_wdata_o;
    logic [ACHK_W-1:0] data_achk_o;
    logic              data_rvalid_i;
    logic              data_rvalidpar_i;
    logic [DW-1:0]     data_rdata_i;
    logic              data_err_i;
    logic [CW-1:0]     outstanding_o;
    logic              integrity_err_o;
    logic              protocol_err_o;

    cv32e40s_data_obi_bounded_interface #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .trans_valid_i(trans_valid_i), .trans_ready_o(trans_ready_o),
        .trans_addr_i(trans_addr_i), .trans_we_i(trans_we_i),
        .trans_be_i(trans_be_i), .trans_wdata_i(trans_wdata_i),
        .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
        .resp_err_o(resp_err_o), .resp_we_o(resp_we_o),
        .data_req_o(data_req_o), .data_reqpar_o(data_reqpar_o),
        .data_gnt_i(data_gnt_i), .data_gntpar_i(data_gntpar_i),
        .data_addr_o(data_addr_o), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_achk_o(data_achk_o),
        .data_rvalid_i(data_rvalid_i), .data_rvalidpar_i(data_rvalidpar_i),
        .data_rdata_i(data_rdata_i), .data_err_i(data_err_i),
        .outstanding_o(outstanding_o), .integrity_err_o(integrity_err_o),
        .protocol_err_o(protocol_err_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int            checks = 0;
    int            fails  = 0;
    logic [DW:0]   exp_q[$];    // {err, rdata} of each driven response
    txn_t          pend_q[$];
    logic          os_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [ACHK_W-1:0] exp_achk(input txn_t t);
        logic [ACHK_W-1:0] r;
        r = '0;
`ifdef CV32E40S_DATA_OBI_ACHK_EN
        for (int i = 0; i < AW / 8; i++) r[i] = ($countones(t.addr[8*i +: 8]) % 2) == 1;
        r[AW/8] = ($countones({t.be, t.we}) % 2) == 0;
        for (int i = 0; i < BW; i++) r[AW/8 + 1 + i] = ($countones(t.wdata[8*i +: 8]) % 2) == 1;
`endif
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic drive_req(input logic [AW-1:0] a, input logic w,
                             input logic [BW-1:0] b, input logic [DW-1:0] d);
        trans_valid_i = 1'b1;
        trans_addr_i  = a;
        trans_we_i    = w;
        trans_be_i    = b;
        trans_wdata_i = d;
    endtask

    task automatic set_bus(input logic g, input logic rv, input logic [DW-1:0] rd, input logic er);
        data_gnt_i       = g;
        data_gntpar_i    = !g;
        data_rvalid_i    = rv;
        data_rvalidpar_i = !rv;
        data_rdata_i     = rd;
        data_err_i       = er;
        if (rv) exp_q.push_back({er, rd});
    endtask

    // ---------------- monitor / reference model ----------------
    txn_t        cur;
    logic        have_pend;
    logic        e_req;
    logic        e_we;
    logic [DW:0] e_rsp;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_req", data_req_o, 0);
            check("rst_outstanding", outstanding_o, 0);
            pend_q.delete();
            os_q.delete();
        end else begin
            have_pend = (pend_q.size() != 0);
            if (have_pend) cur = pend_q[0];
            else           cur = {trans_addr_i, trans_we_i, trans_be_i, trans_wdata_i};
            e_req = have_pend || (trans_valid_i && os_q.size() < MAXO);

            check("req", data_req_o, e_req);
            check("reqpar", data_reqpar_o, !e_req);
            check("trans_ready", trans_ready_o, !have_pend && os_q.size() < MAXO);
            check("outstanding", outstanding_o, os_q.size());
            if (e_req) begin
                check("a_addr", data_addr_o, cur.addr);
                check("a_we", data_we_o, cur.we);
                check("a_be", data_be_o, cur.be);
                check("a_wdata", data_wdata_o, cur.wdata);
                check("a_achk", data_achk_o, exp_achk(cur));
            end
            check("integrity", integrity_err_o,
                  (data_gnt_i == data_gntpar_i) || (data_rvalid_i == data_rvalidpar_i));

            // Response side: it answers the oldest outstanding transaction.
            if (resp_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("resp_spurious", resp_valid_o, 0);
                end else begin
                    e_rsp = exp_q.pop_front();
                    check("resp_rdata", resp_rdata_o, e_rsp[DW-1:0]);
                    check("resp_err", resp_err_o, e_rsp[DW]);
                end
            end
            check("resp_valid", resp_valid_o, data_rvalid_i);
            if (data_rvalid_i && os_q.size() != 0) begin
                e_we = os_q.pop_front();
                check("resp_we", resp_we_o, e_we);
                check("protocol_err", protocol_err_o, 0);
            end else if (data_rvalid_i) begin
                check("resp_we_unexp", resp_we_o, 0);
                check("protocol_err", protocol_err_o, 1);
            end else begin
                check("protocol_err_idle", protocol_err_o, 0);
            end

            // A-channel model update.
            if (e_req && data_gnt_i) begin
                if (have_pend) void'(pend_q.pop_front());
                os_q.push_back(cur.we);
            end else if (e_req && !have_pend) begin
                pend_q.push_back(cur);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        trans_valid_i = 1'b0;
        trans_addr_i = '0;
        trans_we_i = 1'b0;
        trans_be_i = '0;
        trans_wdata_i = '0;
        set_bus(1'b0, 1'b0, '0, 1'b0);
        tick;
        tick;
        rst_n = 1'b1;
        settle;
        check("reset_req", data_req_o, 0);
        check("reset_reqpar", data_reqpar_o, 1);
        check("reset_ready", trans_ready_o, 1);
        check("reset_resp_valid", resp_valid_o, 0);
        check("reset_integrity", integrity_err_o, 0);
        check("reset_protocol", protocol_err_o, 0);
        check("reset_outstanding", outstanding_o, 0);

        // Read granted at once, answered two cycles later.
        tick;
        drive_req(32'h40, 1'b0, 4'hF, 32'h0);
        set_bus(1'b1, 1'b0, '0, 1'b0);
        settle;
        check("t1_ready", trans_ready_o, 1);
        check("t1_out0", outstanding_o, 0);
        tick;
        trans_valid_i = 1'b0;
        set_bus(1'b0, 1'b0, '0, 1'b0);
        settle;
        check("t1_out1", outstanding_o, 1);
        tick;
        set_bus(1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        settle;
        check("t1_rvalid", resp_valid_o, 1);
        check("t1_rdata", resp_rdata_o, 32'hDEADBEEF);
        check("t1_we", resp_we_o, 0);
        tick;
        set_bus(1'b0, 1'b0, '0, 1'b0);
        settle;
        check("t1_out_back0", outstanding_o, 0);

        // Write to 0x100 with grant withheld while the requester moves on.
        tick;
        drive_req(32'h100, 1'b1, 4'hF, 32'h11111111);
        settle;
        check("t2_ready_first", trans_ready_o, 1);
        for (int i = 0; i < 3; i++) begin
            tick;
            drive_req(32'h200, 1'b0, 4'h3, 32'h22222222);
            set_bus(i == 2, 1'b0, '0, 1'b0);
            settle;
            check("t2_hold_addr", data_addr_o, 32'h100);
            check("t2_hold_req", data_req_o, 1);
            check("t2_pending_ready", trans_ready_o, 0);
        end
        tick;
        trans_valid_i = 1'b0;
        set_bus(1'b0, 1'b1, 32'h5, 1'b0);
        settle;
        check("t2_resp_we", resp_we_o, 1);
        tick;
        set_bus(1'b0, 1'b0, '0, 1'b0);

        // Three back-to-back requests with MAX_OUTSTANDING=2.
        tick;
        drive_req(32'h300, 1'b0, 4'h1, 32'h0);
        set_bus(1'b1, 1'b0, '0, 1'b0);
        tick;
        drive_req(32'h304, 1'b1, 4'h2, 32'h33);
        tick;
        drive_req(32'h308, 1'b0, 4'h4, 32'h0);
        settle;
        check("t3_blocked_req", data_req_o, 0);
        check("t3_blocked_ready", trans_ready_o, 0);
        check("t3_full", outstanding_o, 2);
        tick;
        set_bus(1'b1, 1'b1, 32'hA0, 1'b0);
        settle;
        check("t3_still_blocked", data_req_o, 0);
        tick;
        set_bus(1'b1, 1'b0, '0, 1'b0);
        settle;
        check("t3_unblocked_req", data_req_o, 1);
        check("t3_unblocked_ready", trans_ready_o, 1);
        tick;
        trans_valid_i = 1'b0;
        set_bus(1'b0, 1'b1, 32'hA1, 1'b1);
        tick;
        set_bus(1'b0, 1'b1, 32'hA2, 1'b0);
        tick;
        set_bus(1'b0, 1'b0, '0, 1'b0);

        // write, read, write answered in order; third accepted alongside a response.
        tick;
        drive_req(32'h400, 1'b1, 4'hF, 32'h44);
        set_bus(1'b1, 1'b0, '0, 1'b0);
        tick;
        drive_req(32'h404, 1'b0, 4'hF, 32'h0);
        tick;
        trans_valid_i = 1'b0;
        set_bus(1'b0, 1'b1, 32'hB0, 1'b0);
        settle;
        check("t4_we_first", resp_we_o, 1);
        tick;
        drive_req(32'h408, 1'b1, 4'hF, 32'h48);
        set_bus(1'b1, 1'b1, 32'hB1, 1'b0);
        settle;
        check("t4_we_second", resp_we_o, 0);
        check("t4_out_flat", outstanding_o, 1);
        tick;
        trans_valid_i = 1'b0;
        set_bus(1'b0, 1'b1, 32'hB2, 1'b0);
        settle;
        check("t4_we_third", resp_we_o, 1);
        tick;
        set_bus(1'b0, 1'b0, '0, 1'b0);

        // Unexpected rvalid.
        tick;
        set_bus(1'b0, 1'b1, 32'hC0, 1'b0);
        settle;
        check("t5_protocol", protocol_err_o, 1);
        check("t5_out", outstanding_o, 0);
        tick;
        set_bus(1'b0, 1'b0, '0, 1'b0);
        settle;
        check("t5_protocol_clear", protocol_err_o, 0);
        check("t5_out_after", outstanding_o, 0);

        // gnt parity broken.
        tick;
        data_gnt_i = 1'b1;
        data_gntpar_i = 1'b1;
        settle;
        check("t6_integrity", integrity_err_o, 1);
        tick;
        set_bus(1'b0, 1'b0, '0, 1'b0);
        settle;
        check("t6_integrity_clear", integrity_err_o, 0);

        // A-channel checksum.
        tick;
        drive_req(32'h1, 1'b1, 4'hF, 32'h0);
        set_bus(1'b1, 1'b0, '0, 1'b0);
        settle;
`ifdef CV32E40S_DATA_OBI_ACHK_EN
        check("t7_achk_addr0", data_achk_o[0], 1);
        check("t7_achk_bewe", data_achk_o[AW/8], 0);
`else
        check("t7_achk_off", data_achk_o, 0);
`endif
        tick;
        trans_valid_i = 1'b0;
        set_bus(1'b0, 1'b1, 32'hD0, 1'b0);
        tick;
        set_bus(1'b0, 1'b0, '0, 1'b0);

        // Reset while one transaction is outstanding and another is pending.
        tick;
        drive_req(32'h500, 1'b0, 4'hF, 32'h0);
        set_bus(1'b1, 1'b0, '0, 1'b0);
        tick;
        drive_req(32'h504, 1'b1, 4'hF, 32'h55);
        set_bus(1'b0, 1'b0, '0, 1'b0);
        tick;
        trans_valid_i = 1'b0;
        settle;
        check("t8_pending_req", data_req_o, 1);
        rst_n = 1'b0;
        #1;
        check("t8_reset_req", data_req_o, 0);
        check("t8_reset_out", outstanding_o, 0);
        tick;
        tick;
        rst_n = 1'b1;

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            tick;
            trans_valid_i = ($urandom_range(0, 2) != 0);
            trans_addr_i  = AW'($urandom);
            trans_we_i    = 1'($urandom_range(0, 1));
            trans_be_i    = BW'($urandom_range(0, 15));
            trans_wdata_i = DW'($urandom);
            set_bus(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                    DW'($urandom), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 19) == 0) data_gntpar_i = data_gnt_i;
            if ($urandom_range(0, 19) == 0) data_rvalidpar_i = data_rvalid_i;
        end
        tick;
        trans_valid_i = 1'b0;
        set_bus(1'b0, 1'b0, '0, 1'b0);
        tick;
        tick;
        check("exp_q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
